// File: rtl/div_axis_iter.sv
// Iterative radix-2 restoring divider with AXI-stream style operand channels.
//
// Ports:
//   div_clk, resetn            clock; synchronous active-low reset
//   s_axis_dividend_*          dividend channel (tuser = signed-mode flag)
//   s_axis_divisor_*           divisor channel
//   m_axis_dout_tvalid/tdata   one-cycle result pulse, {quotient, remainder}
//
// Each operand channel has its own one-entry hold register, so either operand
// may arrive first. The division starts on the edge where the second one
// transfers. The result appears WIDTH cycles later and has no backpressure.
module div_axis_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 div_clk,
  input  logic                 resetn,
  input  logic                 s_axis_dividend_tvalid,
  output logic                 s_axis_dividend_tready,
  input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
  input  logic                 s_axis_dividend_tuser,
  input  logic                 s_axis_divisor_tvalid,
  output logic                 s_axis_divisor_tready,
  input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
  output logic                 m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 xcap_q, xcap_d;
  logic                 ycap_q, ycap_d;
  logic [WIDTH-1:0]     xh_q, xh_d;
  logic                 sh_q, sh_d;
  logic [WIDTH-1:0]     yh_q, yh_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     ay_q, ay_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     xraw_q, xraw_d;
  logic [2*WIDTH-1:0]   dout_q, dout_d;

  logic                 dvd_fire, dsr_fire, start;
  logic [WIDTH-1:0]     x_sel, y_sel;
  logic                 s_sel;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     rem_n, quo_n;

  // resetn gating keeps both readies low throughout the reset cycle
  assign s_axis_dividend_tready = resetn & (state_q == IDLE) & ~xcap_q;
  assign s_axis_divisor_tready  = resetn & (state_q == IDLE) & ~ycap_q;
  assign m_axis_dout_tvalid     = (state_q == DONE);
  assign m_axis_dout_tdata      = dout_q;

  assign dvd_fire = s_axis_dividend_tvalid & s_axis_dividend_tready;
  assign dsr_fire = s_axis_divisor_tvalid  & s_axis_divisor_tready;
  assign start    = (xcap_q | dvd_fire) & (ycap_q | dsr_fire);

  // Operands come straight from the bus when they transfer on the start edge
  assign x_sel = dvd_fire ? s_axis_dividend_tdata : xh_q;
  assign s_sel = dvd_fire ? s_axis_dividend_tuser : sh_q;
  assign y_sel = dsr_fire ? s_axis_divisor_tdata  : yh_q;

  // One restoring step: shift {rem, quo} left, trial-subtract with a borrow bit
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, ay_q};
    if (!trial[WIDTH]) begin
      rem_n = trial[WIDTH-1:0];
      quo_n = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_n = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xcap_d  = xcap_q;
    ycap_d  = ycap_q;
    xh_d    = xh_q;
    sh_d    = sh_q;
    yh_d    = yh_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    ay_d    = ay_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    xraw_d  = xraw_q;
    dout_d  = dout_q;

    unique case (state_q)
      IDLE: begin
        if (dvd_fire) begin
          xcap_d = 1'b1;
          xh_d   = s_axis_dividend_tdata;
          sh_d   = s_axis_dividend_tuser;
        end
        if (dsr_fire) begin
          ycap_d = 1'b1;
          yh_d   = s_axis_divisor_tdata;
        end
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          xcap_d  = 1'b0;
          ycap_d  = 1'b0;
          rem_d   = '0;
          quo_d   = (s_sel & x_sel[WIDTH-1]) ? ('0 - x_sel) : x_sel;
          ay_d    = (s_sel & y_sel[WIDTH-1]) ? ('0 - y_sel) : y_sel;
          qneg_d  = s_sel & (x_sel[WIDTH-1] ^ y_sel[WIDTH-1]);
          rneg_d  = s_sel & x_sel[WIDTH-1];
          div0_d  = (y_sel == '0);
          xraw_d  = x_sel;
        end
      end
      CALC: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          if (div0_q) begin
            dout_d = {{WIDTH{1'b1}}, xraw_q};
          end else begin
            dout_d = {(qneg_q ? ('0 - quo_n) : quo_n),
                      (rneg_q ? ('0 - rem_n) : rem_n)};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xcap_q  <= 1'b0;
      ycap_q  <= 1'b0;
      xh_q    <= '0;
      sh_q    <= 1'b0;
      yh_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      ay_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      xraw_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xcap_q  <= xcap_d;
      ycap_q  <= ycap_d;
      xh_q    <= xh_d;
      sh_q    <= sh_d;
      yh_q    <= yh_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      ay_q    <= ay_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      xraw_q  <= xraw_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_div_axis_iter.sv
// Self-checking bench for div_axis_iter (WIDTH = 32): table vectors, hand
// sequences for handshake ordering, reset abort and back-to-back operation,
// and random operands checked against an arithmetic reference model.
module tb_div_axis_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        dvd_v, dvd_r, dvd_u;
  logic [31:0] dvd_d;
  logic        dsr_v, dsr_r;
  logic [31:0] dsr_d;
  logic        out_v;
  logic [63:0] out_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_axis_iter #(.WIDTH(32)) dut (
    .div_clk                (clk),
    .resetn                 (resetn),
    .s_axis_dividend_tvalid (dvd_v),
    .s_axis_dividend_tready (dvd_r),
    .s_axis_dividend_tdata  (dvd_d),
    .s_axis_dividend_tuser  (dvd_u),
    .s_axis_divisor_tvalid  (dsr_v),
    .s_axis_divisor_tready  (dsr_r),
    .s_axis_divisor_tdata   (dsr_d),
    .m_axis_dout_tvalid     (out_v),
    .m_axis_dout_tdata      (out_d)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: truncating division, remainder follows dividend sign.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    int xi, yi, q, r;
    if (y == 32'd0) return {32'hFFFF_FFFF, x};
    if (!s) return {x / y, x % y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    xi = x;
    yi = y;
    q  = xi / yi;
    r  = xi % yi;
    return {q[31:0], r[31:0]};
  endfunction

  // Called #1 after the start edge: checks latency, data, pulse width, hold
  // and ready return. Ends in the first IDLE cycle after the pulse.
  task automatic wait_result(input logic [63:0] exp, input string nm);
    int n;
    n = 0;
    chk({nm, ":rdy_calc"}, {62'd0, dvd_r, dsr_r}, 64'd0);
    while (!out_v && n < 80) begin
      tick();
      n++;
    end
    chk({nm, ":latency"}, 64'(n), 64'd32);
    chk({nm, ":dout"}, out_d, exp);
    chk({nm, ":rdy_done"}, {62'd0, dvd_r, dsr_r}, 64'd0);
    tick();
    chk({nm, ":pulse_end"}, {63'd0, out_v}, 64'd0);
    chk({nm, ":hold"}, out_d, exp);
    chk({nm, ":rdy_idle"}, {62'd0, dvd_r, dsr_r}, 64'd3);
  endtask

  // Dividend offered after dd cycles, divisor after ds cycles.
  task automatic xfer(input logic [31:0] x, input logic [31:0] y, input logic s,
                      input int dd, input int ds, input logic [63:0] exp, input string nm);
    bit xd, yd, hx, hy;
    int t;
    xd = 0; yd = 0; t = 0;
    while (!(xd && yd) && t < 20) begin
      dvd_v = !xd && t >= dd;
      dsr_v = !yd && t >= ds;
      if (dvd_v) begin dvd_d = x; dvd_u = s; end
      if (dsr_v) dsr_d = y;
      hx = dvd_v & dvd_r;
      hy = dsr_v & dsr_r;
      tick();
      if (hx) begin xd = 1; dvd_v = 0; dvd_d = $urandom; dvd_u = 1'($urandom); end
      if (hy) begin yd = 1; dsr_v = 0; dsr_d = $urandom; end
      if (xd ^ yd)
        chk({nm, ":rdy_partial"}, {62'd0, dvd_r, dsr_r}, {62'd0, !xd, !yd});
      t++;
    end
    dvd_v = 0;
    dsr_v = 0;
    if (!(xd && yd)) chk({nm, ":handshake_timeout"}, 64'(t), 64'd0);
    else wait_result(exp, nm);
  endtask

  vec_t vecs[8];

  initial begin
    bit hit;
    logic [31:0] rx, ry;
    logic rs;

    vecs[0] = '{32'd7,          32'd2,          1'b0, 64'h00000003_00000001};
    vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 64'hFFFFFFFD_FFFFFFFF};
    vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 64'hFFFFFFFD_00000001};
    vecs[3] = '{32'h1234_5678,  32'd0,          1'b0, 64'hFFFFFFFF_12345678};
    vecs[4] = '{32'h1234_5678,  32'd0,          1'b1, 64'hFFFFFFFF_12345678};
    vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h80000000_00000000};
    vecs[6] = '{32'hFFFF_FFFA,  32'd3,          1'b1, 64'hFFFFFFFE_00000000};
    vecs[7] = '{32'hFFFF_FFFF,  32'd16,         1'b0, 64'h0FFFFFFF_0000000F};

    resetn = 0; dvd_v = 0; dsr_v = 0; dvd_d = '0; dsr_d = '0; dvd_u = 0;
    tick();
    chk("reset:rdy", {62'd0, dvd_r, dsr_r}, 64'd0);
    chk("reset:tvalid", {63'd0, out_v}, 64'd0);
    chk("reset:dout", out_d, 64'd0);
    tick();
    resetn = 1;
    tick();
    chk("post_reset:rdy", {62'd0, dvd_r, dsr_r}, 64'd3);

    for (int i = 0; i < 8; i++)
      xfer(vecs[i].x, vecs[i].y, vecs[i].s, 0, 0, vecs[i].exp, $sformatf("vec%0d", i));

    // Divisor late, then divisor first
    xfer(32'd100, 32'd7, 1'b0, 0, 3, 64'h0000000E_00000002, "dvd_first");
    xfer(32'd100, 32'd7, 1'b0, 2, 0, 64'h0000000E_00000002, "dsr_first");

    // Reset at CALC step 10 aborts the operation
    dvd_v = 1; dsr_v = 1; dvd_d = 32'd1000; dsr_d = 32'd3; dvd_u = 0;
    tick();
    dvd_v = 0; dsr_v = 0;
    repeat (10) tick();
    resetn = 0;
    tick();
    chk("abort:rdy_in_reset", {62'd0, dvd_r, dsr_r}, 64'd0);
    chk("abort:tvalid_in_reset", {63'd0, out_v}, 64'd0);
    resetn = 1;
    tick();
    chk("abort:rdy_after", {62'd0, dvd_r, dsr_r}, 64'd3);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_v) hit = 1;
      tick();
    end
    chk("abort:no_tvalid", {63'd0, hit}, 64'd0);
    xfer(32'd9, 32'd3, 1'b0, 0, 0, 64'h00000003_00000000, "after_abort");

    // Back-to-back with valids held high throughout
    dvd_v = 1; dsr_v = 1; dvd_d = 32'hFFFF_FFFF; dsr_d = 32'd1; dvd_u = 0;
    tick();
    dvd_d = 32'd5; dsr_d = 32'd10;
    wait_result(64'hFFFFFFFF_00000000, "b2b_first");
    tick();
    dvd_v = 0; dsr_v = 0;
    wait_result(64'h00000000_00000005, "b2b_second");

    // Random operands, mixed modes and arrival orders
    for (int i = 0; i < 24; i++) begin
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      rs = 1'($urandom);
      if ($urandom_range(0, 1) == 1) ry = -ry;
      xfer(rx, ry, rs, $urandom_range(0, 3), $urandom_range(0, 3),
           model(rx, ry, rs), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
